// File: rtl/psram_pkg.sv
// Shared PSRAM bus definitions: command bytes, responder states and frame geometry.
// Also imported by memCtrl so both sides of the bus agree on the encoding.
package psram_pkg;
  localparam logic [7:0] CMD_QPI_EN   = 8'h35;
  localparam logic [7:0] CMD_QPI_EXIT = 8'hF5;
  localparam logic [7:0] CMD_WRITE    = 8'h38;
  localparam logic [7:0] CMD_READ     = 8'hEB;

  localparam int ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RWAIT,
    RDATA,
    IGNORE
  } state_e;
endpackage

// File: rtl/psram_byte_ram.sv
// Single-port DEPTH x 8 byte array with synchronous write and registered read (BRAM style).
// The read register is read-first and resets to INIT_BYTE; the array itself is never cleared.
module psram_byte_ram #(
  parameter int         ADDR_BITS = 12,
  parameter logic [7:0] INIT_BYTE = 8'h00
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [7:0]           wdata_i,
  output logic [7:0]           rdata_o
);
  logic [7:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rdata_o <= INIT_BYTE;
    else         rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/psram_qpi_responder.sv
// Device-side QPI PSRAM target: serial command, QPI address, write bursts into a local
// byte array and read bursts returned after WAIT_CYCLES dummy edges.
module psram_qpi_responder
  import psram_pkg::*;
#(
  parameter int         ADDR_BITS   = 12,
  parameter int         WAIT_CYCLES = 6,
  parameter logic [7:0] INIT_BYTE   = 8'h00
) (
  input  logic       i_clkRAM,
  input  logic       reset,
  input  logic       i_psram_cs,
  input  logic [3:0] i_sio,
  output logic [3:0] o_sio,
  output logic       o_sio_oe,
  output logic       o_qpi_mode,
  output logic       o_cmd_err
);
  state_e               state_q;
  logic [7:0]           cnt_q;
  logic [7:0]           cmd_q;
  logic [7:0]           cmd_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [3:0]           hi_q;
  logic                 lo_q;
  logic                 qpi_q;
  logic                 err_q;
  logic                 oe_q;
  logic [3:0]           sio_q;
  logic                 ram_we;
  logic [7:0]           ram_wdata;
  logic [7:0]           ram_rdata;

  // A write only commits with CS still low on the low-nibble edge; in the low-nibble
  // read cycle the array is already pointed at the next byte so it is ready one edge later.
  always_comb begin
    cmd_d     = {cmd_q[6:0], i_sio[0]};
    ram_we    = (state_q == WDATA) && lo_q && !i_psram_cs && !reset;
    ram_wdata = {hi_q, i_sio};
    ram_addr  = (state_q == RDATA && lo_q) ? addr_q + 1'b1 : addr_q;
  end

  psram_byte_ram #(
    .ADDR_BITS (ADDR_BITS),
    .INIT_BYTE (INIT_BYTE)
  ) u_ram (
    .clk_i   (i_clkRAM),
    .reset_i (reset),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge i_clkRAM) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= 1'b0;
      qpi_q   <= 1'b0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
      sio_q   <= '0;
    end else begin
      err_q <= 1'b0;
      if (i_psram_cs) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cmd_q   <= cmd_d;
            cnt_q   <= 8'd1;
            state_q <= CMD;
          end
          CMD: begin
            cmd_q <= cmd_d;
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              cnt_q   <= '0;
              state_q <= IGNORE;
              case (cmd_d)
                CMD_QPI_EN:   qpi_q <= 1'b1;
                CMD_QPI_EXIT: qpi_q <= 1'b0;
                CMD_WRITE, CMD_READ: begin
                  if (qpi_q) state_q <= ADDR;
                  else       err_q   <= 1'b1;
                end
                default:      err_q <= 1'b1;
              endcase
            end
          end
          ADDR: begin
            addr_q <= ADDR_BITS'({addr_q, i_sio});
            cnt_q  <= cnt_q + 8'd1;
            if (cnt_q == 8'(ADDR_NIBBLES - 1)) begin
              cnt_q   <= '0;
              lo_q    <= 1'b0;
              state_q <= (cmd_q == CMD_WRITE) ? WDATA : RWAIT;
            end
          end
          WDATA: begin
            if (!lo_q) begin
              hi_q <= i_sio;
              lo_q <= 1'b1;
            end else begin
              lo_q   <= 1'b0;
              addr_q <= addr_q + 1'b1;
            end
          end
          RWAIT: begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'(WAIT_CYCLES - 1)) begin
              sio_q   <= ram_rdata[7:4];
              oe_q    <= 1'b1;
              lo_q    <= 1'b1;
              state_q <= RDATA;
            end
          end
          RDATA: begin
            if (lo_q) begin
              sio_q  <= ram_rdata[3:0];
              addr_q <= addr_q + 1'b1;
              lo_q   <= 1'b0;
            end else begin
              sio_q <= ram_rdata[7:4];
              lo_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_sio      = sio_q;
  assign o_sio_oe   = oe_q;
  assign o_qpi_mode = qpi_q;
  assign o_cmd_err  = err_q;
endmodule

// File: tb/tb_psram_qpi_responder.sv
// Bench for psram_qpi_responder: drives memCtrl-style frames, keeps a byte-array model and
// scores read nibbles against a queue filled when each read is issued.
module tb_psram_qpi_responder;
  localparam int WAIT = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_psram_cs;
  logic [3:0] i_sio;
  logic [3:0] o_sio;
  logic       o_sio_oe;
  logic       o_qpi_mode;
  logic       o_cmd_err;

  logic [7:0] model [4096];
  logic [3:0] exp_q [$];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  psram_qpi_responder #(
    .ADDR_BITS   (12),
    .WAIT_CYCLES (WAIT),
    .INIT_BYTE   (8'h00)
  ) dut (
    .i_clkRAM   (clk),
    .reset      (reset),
    .i_psram_cs (i_psram_cs),
    .i_sio      (i_sio),
    .o_sio      (o_sio),
    .o_sio_oe   (o_sio_oe),
    .o_qpi_mode (o_qpi_mode),
    .o_cmd_err  (o_cmd_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs of the rising edge are seen on return.
  task automatic edge_(input logic cs, input logic [3:0] sio);
    i_psram_cs = cs;
    i_sio      = sio;
    @(negedge clk);
  endtask

  task automatic cs_high();
    edge_(1'b1, 4'h0);
    edge_(1'b1, 4'h0);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic exp_err);
    for (int i = 7; i >= 0; i--) edge_(1'b0, {3'b000, c[i]});
    chk("cmd_err", o_cmd_err, exp_err);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) edge_(1'b0, a[4*i +: 4]);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [31:0] data, input int n);
    logic [7:0]  b;
    logic [11:0] ma;
    send_cmd(8'h38, 1'b0);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      b  = data[8*(n-1-i) +: 8];
      ma = a[11:0] + 12'(i);
      edge_(1'b0, b[7:4]);
      chk("wr_oe", o_sio_oe, 1'b0);
      edge_(1'b0, b[3:0]);
      model[ma] = b;
    end
    cs_high();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [11:0] ma;
    logic [3:0]  e;
    for (int i = 0; i < n; i++) begin
      ma = a[11:0] + 12'(i);
      exp_q.push_back(model[ma][7:4]);
      exp_q.push_back(model[ma][3:0]);
    end
    send_cmd(8'hEB, 1'b0);
    send_addr(a);
    for (int k = 14; k <= 12 + WAIT + 2*n; k++) begin
      edge_(1'b0, 4'h0);
      chk("rd_oe", o_sio_oe, k >= 13 + WAIT);
      if (o_sio_oe) begin
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rd_nibble", o_sio, e);
        end
      end
    end
    chk("sb_empty", exp_q.size(), 0);
    exp_q.delete();
    cs_high();
    chk("oe_drop", o_sio_oe, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    i_psram_cs = 1'b1;
    i_sio = 4'h0;
    @(negedge clk);
    edge_(1'b1, 4'h0);
    edge_(1'b0, 4'h1);
    chk("rst_sio", o_sio, 4'h0);
    chk("rst_oe", o_sio_oe, 1'b0);
    chk("rst_qpi", o_qpi_mode, 1'b0);
    chk("rst_err", o_cmd_err, 1'b0);
    reset = 1'b0;
    cs_high();

    // Known contents at 0xAAA, then reset drops QPI mode but keeps the array
    send_cmd(8'h35, 1'b0);
    cs_high();
    chk("qpi_on", o_qpi_mode, 1'b1);
    do_write(24'h00AAAA, 32'h5A, 1);
    reset = 1'b1;
    edge_(1'b1, 4'h0);
    reset = 1'b0;
    chk("qpi_rst", o_qpi_mode, 1'b0);

    // Write without QPI is refused
    send_cmd(8'h38, 1'b1);
    send_addr(24'h00AAAA);
    chk("err_pulse_end", o_cmd_err, 1'b0);
    edge_(1'b0, 4'hF);
    edge_(1'b0, 4'h0);
    cs_high();
    send_cmd(8'h35, 1'b0);
    cs_high();
    chk("qpi_on2", o_qpi_mode, 1'b1);
    do_read(24'h00AAAA, 1);

    // Normal write then timed read of the same byte
    do_write(24'h00AAAA, 32'hF0, 1);
    do_read(24'h00AAAA, 1);

    // Burst crossing the top of the array
    do_write(24'h000FFF, 32'h11223344, 4);
    do_read(24'h000FFF, 4);

    // Upper address bits are ignored
    do_read(24'h123001, 1);

    // Unknown command in QPI mode, then exit and re-enter
    send_cmd(8'h00, 1'b1);
    cs_high();
    send_cmd(8'hF5, 1'b0);
    cs_high();
    chk("qpi_off", o_qpi_mode, 1'b0);
    send_cmd(8'h35, 1'b0);
    cs_high();

    // CS rising on the low-nibble edge must not commit
    send_cmd(8'h38, 1'b0);
    send_addr(24'h000001);
    edge_(1'b0, 4'h7);
    chk("abort_oe_hi", o_sio_oe, 1'b0);
    edge_(1'b1, 4'h7);
    chk("abort_oe_lo", o_sio_oe, 1'b0);
    cs_high();
    do_read(24'h000001, 1);

    // Reset in the middle of read data
    send_cmd(8'hEB, 1'b0);
    send_addr(24'h000000);
    for (int k = 14; k <= 13 + WAIT; k++) edge_(1'b0, 4'h0);
    chk("mid_oe", o_sio_oe, 1'b1);
    chk("mid_hi", o_sio, model[0][7:4]);
    reset = 1'b1;
    edge_(1'b0, 4'h0);
    chk("rst_rd_oe", o_sio_oe, 1'b0);
    chk("rst_rd_qpi", o_qpi_mode, 1'b0);
    reset = 1'b0;
    cs_high();
    send_cmd(8'hEB, 1'b1);
    cs_high();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
